// File: rtl/mem_sequencer_if.sv
// Command handshake and memory-block control bus between the instruction decoder and mem_sequencer.
// The requester side drives commands and stall; the sequencer side drives every control word.
interface mem_sequencer_if;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic       cmd_ready;
   logic       stall;
   logic [2:0] addroutctl;
   logic [2:0] addrloadctl;
   logic [3:0] outctl;
   logic [3:0] loadctl;
   logic       spinc;
   logic       spdec;
   logic       ext_oe;
   logic       ext_ld;
   logic       done;
   logic       err;

   modport master (
      output cmd_valid, cmd, stall,
      input  cmd_ready, addroutctl, addrloadctl, outctl, loadctl,
             spinc, spdec, ext_oe, ext_ld, done, err
   );

   modport slave (
      input  cmd_valid, cmd, stall,
      output cmd_ready, addroutctl, addrloadctl, outctl, loadctl,
             spinc, spdec, ext_oe, ext_ld, done, err
   );
endinterface

// File: rtl/mem_sequencer.sv
// Memory-block sequencer: expands one accepted bus command into one or two control-word steps.
// Control words are decoded combinationally from the registered step and the live stall input.
module mem_sequencer #(
   parameter logic [2:0] AO_IDLE = 3'd7,
   parameter logic [3:0] OC_IDLE = 4'b0111,
   parameter logic [3:0] LC_IDLE = 4'b0111
) (
   input  logic            clk,
   input  logic            rstn,
   mem_sequencer_if.slave  bus
);

   localparam logic [2:0] AO_TX  = 3'd0;
   localparam logic [2:0] AO_SP  = 3'd3;
   localparam logic [2:0] AO_LR  = 3'd4;
   localparam logic [2:0] AO_PC  = 3'd5;

   localparam logic [3:0] OC_MEM = 4'b0011;
   localparam logic [3:0] LC_IR  = 4'b0100;
   localparam logic [3:0] LC_MEM = 4'b0011;
   localparam logic [3:0] LC_TXH = 4'b0101;
   localparam logic [3:0] LC_TXL = 4'b1011;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH0,
      S_LDTX0,
      S_LDTX1,
      S_JUMP0,
      S_PUSH0,
      S_PUSH1,
      S_POP0,
      S_POP1,
      S_CALL0,
      S_CALL1,
      S_ILL0
   } state_t;

   state_t st, nxt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) st <= S_IDLE;
      else       st <= nxt;
   end

   // Next state: the command is captured only in IDLE; busy steps advance only when not stalled.
   always_comb begin
      nxt = st;
      if (st == S_IDLE) begin
         if (bus.cmd_valid) begin
            case (bus.cmd)
               3'd0:    nxt = S_FETCH0;
               3'd1:    nxt = S_LDTX0;
               3'd2:    nxt = S_JUMP0;
               3'd3:    nxt = S_PUSH0;
               3'd4:    nxt = S_POP0;
               3'd5:    nxt = S_CALL0;
               default: nxt = S_ILL0;
            endcase
         end
      end else if (!bus.stall) begin
         case (st)
            S_LDTX0: nxt = S_LDTX1;
            S_PUSH0: nxt = S_PUSH1;
            S_POP0:  nxt = S_POP1;
            S_CALL0: nxt = S_CALL1;
            default: nxt = S_IDLE;
         endcase
      end
   end

   // Control words: each step drives at most one address-bus driver and one mbus driver.
   always_comb begin
      bus.cmd_ready   = (st == S_IDLE);
      bus.addroutctl  = AO_IDLE;
      bus.addrloadctl = AO_IDLE;
      bus.outctl      = OC_IDLE;
      bus.loadctl     = LC_IDLE;
      bus.spinc       = 1'b1;
      bus.spdec       = 1'b1;
      bus.ext_oe      = 1'b0;
      bus.ext_ld      = 1'b0;
      bus.done        = 1'b0;
      bus.err         = 1'b0;
      if (!bus.stall) begin
         case (st)
            S_FETCH0: begin
               bus.addroutctl = AO_PC;
               bus.outctl     = OC_MEM;
               bus.loadctl    = LC_IR;
               bus.done       = 1'b1;
            end
            S_LDTX0: begin
               bus.addroutctl = AO_PC;
               bus.outctl     = OC_MEM;
               bus.loadctl    = LC_TXL;
            end
            S_LDTX1: begin
               bus.addroutctl = AO_PC;
               bus.outctl     = OC_MEM;
               bus.loadctl    = LC_TXH;
               bus.done       = 1'b1;
            end
            S_JUMP0: begin
               bus.addroutctl  = AO_TX;
               bus.addrloadctl = AO_PC;
               bus.done        = 1'b1;
            end
            S_PUSH0: bus.spdec = 1'b0;
            S_PUSH1: begin
               bus.addroutctl = AO_SP;
               bus.loadctl    = LC_MEM;
               bus.ext_oe     = 1'b1;
               bus.done       = 1'b1;
            end
            S_POP0: begin
               bus.addroutctl = AO_SP;
               bus.outctl     = OC_MEM;
               bus.ext_ld     = 1'b1;
            end
            S_POP1: begin
               bus.spinc = 1'b0;
               bus.done  = 1'b1;
            end
            S_CALL0: begin
               bus.addroutctl  = AO_PC;
               bus.addrloadctl = AO_LR;
            end
            S_CALL1: begin
               bus.addroutctl  = AO_TX;
               bus.addrloadctl = AO_PC;
               bus.done        = 1'b1;
            end
            S_ILL0: begin
               bus.done = 1'b1;
               bus.err  = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
